// File: rtl/pwm_grp_rsp_ctrl_pkg.sv
// PWM group response controller: shared constants and helpers.
// Group counts of the surrounding periplex plus response packet layout.
package pwm_grp_rsp_ctrl_pkg;

    // Channel counts of the peripheral groups that precede PWM in the select map.
    localparam int PERIPLEX_TOTAL_UART       = 2;
    localparam int PERIPLEX_TOTAL_I2C        = 2;
    localparam int PERIPLEX_TOTAL_GPIO_CTRLS = 2;
    localparam int PERIPLEX_TOTAL_PWM        = 4;

    localparam int PWM_SEL_BASE_DEFAULT =
        PERIPLEX_TOTAL_UART + PERIPLEX_TOTAL_I2C + PERIPLEX_TOTAL_GPIO_CTRLS;

    // Packet layout: [47:0] value, [50:48] byte-count tag.
    localparam int PWM_RSP_TAG_LSB = 48;
    localparam int PWM_RSP_TAG_W   = 3;

    // Tags 1..5 are literal byte counts; 0, 6 and 7 all mean a full 6-byte payload.
    function automatic logic [PWM_RSP_TAG_W-1:0] tag_to_len(
        input logic [PWM_RSP_TAG_W-1:0] tag
    );
        if (tag >= 3'd1 && tag <= 3'd5) begin
            return tag;
        end
        return 3'd6;
    endfunction

endpackage

// File: rtl/pwm_grp_rsp_ctrl_rr_arbiter.sv
// Round-robin priority search across the PWM response FIFOs.
// Purely combinational; the pointer is owned by the controller.
module pwm_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          any_o
);

    // Scan from farthest to nearest so the closest requester at/after ptr wins.
    always_comb begin
        int j;
        grant_o = '0;
        any_o   = |req_i;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req_i[IW'(j)]) begin
                grant_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/pwm_grp_rsp_ctrl.sv
// PWM group response controller: pops one packet per beat from the
// per-channel response FIFOs and presents it to the frame encoder.
module pwm_grp_rsp_ctrl
    import pwm_grp_rsp_ctrl_pkg::*;
#(
    parameter int SEL_WIDTH        = 7,
    parameter int LEN_WIDTH        = 7,
    parameter int VALUE_WIDTH      = 48,
    parameter int ASYNC_FIFO_WIDTH = 51,
    parameter int TOTAL_PWM        = PERIPLEX_TOTAL_PWM,
    parameter int SEL_BASE         = PWM_SEL_BASE_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  pwm_grp_en,
    input  logic [TOTAL_PWM-1:0]                  rd_fifo_empty,
    input  logic [TOTAL_PWM*ASYNC_FIFO_WIDTH-1:0] rd_fifo_data,
    output logic [TOTAL_PWM-1:0]                  rd_fifo_enable,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [SEL_WIDTH-1:0]                  rsp_slv_sel,
    output logic [LEN_WIDTH-1:0]                  rsp_len,
    output logic [VALUE_WIDTH-1:0]                rsp_value
);

    localparam int IW     = (TOTAL_PWM > 1) ? $clog2(TOTAL_PWM) : 1;
    localparam int NBYTES = VALUE_WIDTH / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] CAP  = 2'd2;
    localparam logic [1:0] SEND = 2'd3;

    logic [1:0]             state_q,  state_d;
    logic [IW-1:0]          grant_q,  grant_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [TOTAL_PWM-1:0]   rd_en_q,  rd_en_d;
    logic                   valid_q,  valid_d;
    logic [SEL_WIDTH-1:0]   sel_q,    sel_d;
    logic [LEN_WIDTH-1:0]   len_q,    len_d;
    logic [VALUE_WIDTH-1:0] value_q,  value_d;

    logic [IW-1:0]               arb_idx;
    logic                        arb_any;
    logic                        start;
    logic [ASYNC_FIFO_WIDTH-1:0] slice;
    logic [PWM_RSP_TAG_W-1:0]    tag;
    logic [LEN_WIDTH-1:0]        len_c;
    logic [VALUE_WIDTH-1:0]      value_c;

    pwm_rr_arbiter #(
        .N  (TOTAL_PWM),
        .IW (IW)
    ) u_arb (
        .req_i   (~rd_fifo_empty),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_idx),
        .any_o   (arb_any)
    );

    assign start = (state_q == IDLE) && pwm_grp_en && arb_any;
    assign slice = rd_fifo_data[int'(grant_q)*ASYNC_FIFO_WIDTH +: ASYNC_FIFO_WIDTH];
    assign tag   = slice[PWM_RSP_TAG_LSB +: PWM_RSP_TAG_W];
    assign len_c = LEN_WIDTH'(tag_to_len(tag));

    // Keep only the bytes below the decoded length; upper bytes read as zero.
    always_comb begin
        value_c = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (b < int'(len_c)) begin
                value_c[b*8 +: 8] = slice[b*8 +: 8];
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            rd_en_q  <= '0;
            valid_q  <= 1'b0;
            sel_q    <= '0;
            len_q    <= '0;
            value_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            rd_en_q  <= rd_en_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            len_q    <= len_d;
            value_q  <= value_d;
        end
    end

    // Next-state: pop, wait out the FIFO read latency, capture, hand off.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD;
            RD:      state_d = CAP;
            CAP:     state_d = SEND;
            SEND:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: one-cycle strobe in RD, beat built in CAP, held through SEND.
    always_comb begin
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        rd_en_d  = '0;
        valid_d  = valid_q;
        sel_d    = sel_q;
        len_d    = len_q;
        value_d  = value_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    grant_d          = arb_idx;
                    rd_en_d[arb_idx] = 1'b1;
                end
            end
            CAP: begin
                sel_d    = SEL_WIDTH'(SEL_BASE) + SEL_WIDTH'(grant_q);
                len_d    = len_c;
                value_d  = value_c;
                valid_d  = 1'b1;
                rr_ptr_d = (grant_q == IW'(TOTAL_PWM - 1)) ? '0 : grant_q + 1'b1;
            end
            SEND: begin
                if (rsp_ready) valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign rd_fifo_enable = rd_en_q;
    assign rsp_valid      = valid_q;
    assign rsp_slv_sel    = sel_q;
    assign rsp_len        = len_q;
    assign rsp_value      = value_q;

endmodule

// File: tb/tb_pwm_grp_rsp_ctrl.sv
// Directed bench for pwm_grp_rsp_ctrl with a behavioural FIFO per channel.
// Tag decode is table-driven; arbitration and handshake corners are sequences.
module tb_pwm_grp_rsp_ctrl;

    localparam int NCH  = 4;
    localparam int BASE = 10;
    localparam int FW   = 51;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NCH-1:0]    rd_fifo_empty;
    logic [NCH*FW-1:0] rd_fifo_data;
    logic [NCH-1:0]    rd_fifo_enable;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [6:0]        rsp_slv_sel;
    logic [6:0]        rsp_len;
    logic [47:0]       rsp_value;

    pwm_grp_rsp_ctrl #(
        .TOTAL_PWM (NCH),
        .SEL_BASE  (BASE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pwm_grp_en     (en),
        .rd_fifo_empty  (rd_fifo_empty),
        .rd_fifo_data   (rd_fifo_data),
        .rd_fifo_enable (rd_fifo_enable),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_slv_sel    (rsp_slv_sel),
        .rsp_len        (rsp_len),
        .rsp_value      (rsp_value)
    );

    always #5 clk = ~clk;

    logic [FW-1:0] mem [NCH][8];
    logic [FW-1:0] dout [NCH];
    int push_cnt [NCH];
    int pop_cnt  [NCH];
    int strobe_cnt = 0;
    int multi_hot  = 0;
    int n_cmp      = 0;
    int n_fail     = 0;

    initial begin
        for (int n = 0; n < NCH; n++) begin
            push_cnt[n] = 0;
            pop_cnt[n]  = 0;
            dout[n]     = '0;
        end
    end

    always @(posedge clk) begin
        for (int n = 0; n < NCH; n++) begin
            if (rd_fifo_enable[n] && push_cnt[n] != pop_cnt[n]) begin
                dout[n]    <= mem[n][pop_cnt[n] % 8];
                pop_cnt[n] <= pop_cnt[n] + 1;
            end
        end
        strobe_cnt <= strobe_cnt + $countones(rd_fifo_enable);
        if ($countones(rd_fifo_enable) > 1) multi_hot <= multi_hot + 1;
    end

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            rd_fifo_empty[n]          = (push_cnt[n] == pop_cnt[n]);
            rd_fifo_data[n*FW +: FW]  = dout[n];
        end
    end

    typedef struct {
        logic [2:0]  tag;
        logic [47:0] val;
        logic [6:0]  len;
        logic [47:0] exp;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [2:0] tag, input logic [47:0] v);
        mem[ch][push_cnt[ch] % 8] = {tag, v};
        push_cnt[ch]++;
    endtask

    task automatic cyc1();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_beat(output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            cyc1();
            cyc++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_timeout: got no rsp_valid want valid within 40");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc1();
        cyc1();
        rst = 1'b0;
    endtask

    int lat;
    int s0;

    initial begin
        vt[0] = '{3'd0, 48'hFFFFFFFFFFFF, 7'd6, 48'hFFFFFFFFFFFF};
        vt[1] = '{3'd5, 48'hFFFFFFFFFFFF, 7'd5, 48'h00FFFFFFFFFF};
        vt[2] = '{3'd6, 48'hFFFFFFFFFFFF, 7'd6, 48'hFFFFFFFFFFFF};
        vt[3] = '{3'd7, 48'hFFFFFFFFFFFF, 7'd6, 48'hFFFFFFFFFFFF};
        vt[4] = '{3'd3, 48'hAABBCCDDEEFF, 7'd3, 48'h000000DDEEFF};
        vt[5] = '{3'd1, 48'h123456789ABC, 7'd1, 48'h0000000000BC};
        vt[6] = '{3'd2, 48'h123456789ABC, 7'd2, 48'h000000009ABC};
        vt[7] = '{3'd4, 48'h123456789ABC, 7'd4, 48'h000056789ABC};

        rst       = 1'b1;
        en        = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        do_reset();

        chk("rst_enable", rd_fifo_enable, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_sel", rsp_slv_sel, 0);
        chk("rst_len", rsp_len, 0);
        chk("rst_value", rsp_value, 0);

        // Tag decode table, all on channel 0.
        for (int i = 0; i < 8; i++) begin
            s0 = strobe_cnt;
            push(0, vt[i].tag, vt[i].val);
            wait_beat(lat);
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_sel", i), rsp_slv_sel, BASE);
            chk($sformatf("v%0d_len", i), rsp_len, vt[i].len);
            chk($sformatf("v%0d_value", i), rsp_value, vt[i].exp);
            chk($sformatf("v%0d_strobes", i), strobe_cnt - s0, 1);
            cyc1();
            chk($sformatf("v%0d_valid_drop", i), rsp_valid, 0);
        end

        // Round-robin over ch0, ch1 and the last channel, two packets each.
        do_reset();
        s0 = strobe_cnt;
        for (int p = 0; p < 2; p++) begin
            push(0, 3'd6, 48'h000 + 48'(p));
            push(1, 3'd6, 48'h100 + 48'(p));
            push(NCH - 1, 3'd6, 48'h300 + 48'(p));
        end
        for (int b = 0; b < 6; b++) begin
            wait_beat(lat);
            case (b % 3)
                0: chk($sformatf("rr%0d_sel", b), rsp_slv_sel, BASE + 0);
                1: chk($sformatf("rr%0d_sel", b), rsp_slv_sel, BASE + 1);
                default: chk($sformatf("rr%0d_sel", b), rsp_slv_sel, BASE + NCH - 1);
            endcase
            chk($sformatf("rr%0d_pkt", b), rsp_value[7:0], b / 3);
        end
        cyc1();
        chk("rr_strobes", strobe_cnt - s0, 6);

        // Backpressure: beat held for 10 cycles while ch1 waits.
        do_reset();
        rsp_ready = 1'b0;
        push(2, 3'd6, 48'h222222222222);
        wait_beat(lat);
        chk("bp_sel", rsp_slv_sel, BASE + 2);
        s0 = strobe_cnt;
        push(1, 3'd2, 48'h111111111111);
        for (int i = 0; i < 10; i++) begin
            cyc1();
            chk($sformatf("bp%0d_valid", i), rsp_valid, 1);
            chk($sformatf("bp%0d_sel", i), rsp_slv_sel, BASE + 2);
            chk($sformatf("bp%0d_len", i), rsp_len, 6);
            chk($sformatf("bp%0d_value", i), rsp_value, 48'h222222222222);
        end
        chk("bp_no_strobe", strobe_cnt - s0, 0);
        rsp_ready = 1'b1;
        cyc1();
        rsp_ready = 1'b0;
        chk("bp_accept", rsp_valid, 0);
        wait_beat(lat);
        chk("bp_next_sel", rsp_slv_sel, BASE + 1);
        chk("bp_next_value", rsp_value, 48'h000000001111);
        chk("bp_next_strobe", strobe_cnt - s0, 1);
        rsp_ready = 1'b1;
        cyc1();

        // Enable gating.
        do_reset();
        en = 1'b0;
        s0 = strobe_cnt;
        push(0, 3'd1, 48'h0000000000A5);
        repeat (10) cyc1();
        chk("en_off_strobes", strobe_cnt - s0, 0);
        chk("en_off_valid", rsp_valid, 0);
        en        = 1'b1;
        rsp_ready = 1'b0;
        wait_beat(lat);
        chk("en_on_sel", rsp_slv_sel, BASE);
        chk("en_on_value", rsp_value, 48'hA5);
        push(3, 3'd1, 48'h00000000005A);
        en        = 1'b0;
        rsp_ready = 1'b1;
        cyc1();
        chk("en_drop_accept", rsp_valid, 0);
        repeat (10) cyc1();
        chk("en_drop_strobes", strobe_cnt - s0, 1);
        chk("en_drop_valid", rsp_valid, 0);
        en = 1'b1;
        wait_beat(lat);
        chk("en_resume_sel", rsp_slv_sel, BASE + 3);
        cyc1();

        // Reset in CAP after rr_ptr has moved past ch2.
        do_reset();
        push(2, 3'd6, 48'h0);
        wait_beat(lat);
        chk("rm_pre_sel", rsp_slv_sel, BASE + 2);
        cyc1();
        push(1, 3'd6, 48'hDEAD);
        cyc1();
        chk("rm_rd_strobe", rd_fifo_enable, 4'b0010);
        cyc1();
        rst = 1'b1;
        cyc1();
        chk("rm_enable", rd_fifo_enable, 0);
        chk("rm_valid", rsp_valid, 0);
        chk("rm_sel", rsp_slv_sel, 0);
        chk("rm_len", rsp_len, 0);
        chk("rm_value", rsp_value, 0);
        rst = 1'b0;
        push(NCH - 1, 3'd6, 48'h3);
        push(0, 3'd6, 48'h0);
        wait_beat(lat);
        chk("rm_first_sel", rsp_slv_sel, BASE + 0);
        wait_beat(lat);
        chk("rm_second_sel", rsp_slv_sel, BASE + NCH - 1);
        cyc1();

        chk("one_hot_strobe", multi_hot, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
